nip_bram_pixel_reader: RTL and testbench

//  Read side of the 8-bit-write / 32-bit-read pixel frame BRAM. It walks BRAM port B

---
 rtl/nip_bram_pixel_reader.sv | 165 ++++++++++++++++
 tb/tb_nip_bram_pixel_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nip_bram_pixel_reader.sv
// Purpose : streams one frame out of the 32-bit read port of the pixel BRAM as 8-bit raster pixels.
// Latency : start -> first pixel valid in 2+READ_LAT cycles; 4 pixels per 5+READ_LAT cycles when never stalled.
// Backpressure: pix_ready low holds the current pixel and its flags stable; only the EMIT phase stretches.
//
// Ports
//   clk_in1   port-B clock, all logic on its rising edge
//   RESET     synchronous active-high reset, aborts a frame with no done pulse
//   start     one-cycle request for a frame, honoured only while idle
//   busy      high from the cycle after start is accepted until done
//   addrb     registered BRAM word address (changes only when a word request begins)
//   doutb     BRAM read data, sampled once per word after READ_LAT cycles
//   pix_data  current pixel; pix_valid/pix_ready handshake
//   pix_sof   first pixel of the frame; pix_eof last pixel of the frame
//   pix_eol   last pixel of a row (present only when NIP_LINE_FLAGS_EN is defined)
//   done      one-cycle pulse in the first idle cycle after the last pixel is accepted
//
// Build option: define NIP_LINE_FLAGS_EN to add the pix_eol output.
module nip_bram_pixel_reader #(
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 9,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 32,
    parameter int READ_LAT = 1
) (
    input  logic                 clk_in1,
    input  logic                 RESET,
    input  logic                 start,
    output logic                 busy,
    output logic [ADDR_W-1:0]    addrb,
    input  logic [4*PIX_W-1:0]   doutb,
    output logic [PIX_W-1:0]     pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_sof,
    output logic                 pix_eof,
`ifdef NIP_LINE_FLAGS_EN
    output logic                 pix_eol,
`endif
    output logic                 done
);

    localparam int N_WORDS = IMG_W * IMG_H / 4;
    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [1:0]        WAIT_LAST = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_W-1:0]          word_cnt;
    logic [1:0]                 lane;
    logic [1:0]                 wait_cnt;
    logic [3:0][PIX_W-1:0]      word_reg;
    logic [COL_W-1:0]           col;
    logic [ROW_W-1:0]           row;

    logic accept;
    logic wait_last;
    logic last_lane;
    logic last_word;

    assign accept    = pix_valid && pix_ready;
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign last_lane = (lane == 2'd3);
    assign last_word = (word_cnt == LAST_WORD);

    // Outputs are decoded from registered state only, so they are glitch-free
    // and naturally hold while the consumer stalls.
    assign busy      = (state != S_IDLE);
    assign pix_valid = (state == S_EMIT);
    assign pix_data  = word_reg[lane];
    assign pix_sof   = pix_valid && (row == '0) && (col == '0);
    assign pix_eof   = pix_valid && (row == ROW_LAST) && (col == COL_LAST);
`ifdef NIP_LINE_FLAGS_EN
    assign pix_eol   = pix_valid && (col == COL_LAST);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: if (wait_last) state_nxt = S_EMIT;
            S_EMIT: begin
                if (accept && last_lane) begin
                    state_nxt = last_word ? S_IDLE : S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in1) begin
        if (RESET) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            addrb    <= '0;
            lane     <= '0;
            wait_cnt <= '0;
            word_reg <= '0;
            col      <= '0;
            row      <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_cnt <= '0;
                        addrb    <= '0;
                        col      <= '0;
                        row      <= '0;
                    end
                end
                S_REQ: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_last) begin
                        word_reg <= doutb;
                        lane     <= '0;
                    end
                end
                S_EMIT: begin
                    if (accept) begin
                        lane <= lane + 2'd1;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
                        end else begin
                            col <= col + COL_ONE;
                        end
                        if (last_lane) begin
                            // The address moves only here (and on frame start), i.e. on
                            // entry to the request phase, and never past the last word.
                            if (last_word) begin
                                done <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + ADDR_ONE;
                                addrb    <= word_cnt + ADDR_ONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nip_bram_pixel_reader.sv
// Purpose : exercises the pixel reader at READ_LAT 1 and 2 side by side against a raster-index model.
// Latency : each instance runs its own scenario list concurrently on a shared clock.
// Backpressure: pix_ready is either held high or randomized per cycle with $urandom.
module tb_nip_bram_pixel_reader;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 9;
    localparam int IMG_W  = 64;
    localparam int IMG_H  = 32;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWORD  = NPIX / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Word n holds pixels 4n..4n+3 with pixel i == i mod 256, low byte first.
    logic [31:0] mem [NWORD];
    initial begin
        for (int n = 0; n < NWORD; n++) begin
            mem[n] = {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
        end
    end

    task automatic chk(input int inst, input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL lat%0d %s: got 0x%0h expected 0x%0h", inst, tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst_g
        localparam int L = g + 1;

        logic              rst;
        logic              start;
        logic              busy;
        logic [ADDR_W-1:0] addrb;
        logic [31:0]       doutb;
        logic [31:0]       d1;
        logic [31:0]       d2;
        logic [PIX_W-1:0]  pix_data;
        logic              pix_valid;
        logic              pix_ready;
        logic              pix_sof;
        logic              pix_eof;
        logic              done;
`ifdef NIP_LINE_FLAGS_EN
        logic              pix_eol;
`endif
        bit                rnd = 1'b0;
        bit                fin = 1'b0;

        // BRAM port B model with L cycles from address change to data.
        always @(posedge clk) begin
            d1 <= mem[addrb];
            d2 <= d1;
        end
        assign doutb = (L == 1) ? d1 : d2;

        nip_bram_pixel_reader #(
            .PIX_W   (PIX_W),
            .ADDR_W  (ADDR_W),
            .IMG_W   (IMG_W),
            .IMG_H   (IMG_H),
            .READ_LAT(L)
        ) dut (
            .clk_in1  (clk),
            .RESET    (rst),
            .start    (start),
            .busy     (busy),
            .addrb    (addrb),
            .doutb    (doutb),
            .pix_data (pix_data),
            .pix_valid(pix_valid),
            .pix_ready(pix_ready),
            .pix_sof  (pix_sof),
            .pix_eof  (pix_eof),
`ifdef NIP_LINE_FLAGS_EN
            .pix_eol  (pix_eol),
`endif
            .done     (done)
        );

        // Reference model: next expected raster index plus frame bookkeeping.
        int         exp_idx   = 0;
        int         frame_pix = 0;
        int         done_cnt  = 0;
        int         busy_cyc  = 0;
        int         eol_cnt   = 0;
        bit         pend_done = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;

        always @(negedge clk) begin
            if (rst) begin
                exp_idx    = 0;
                pend_done  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                chk(L, "done", 32'(done), 32'(pend_done));
                if (done) begin
                    done_cnt++;
                    chk(L, "busy_at_done", 32'(busy), 32'd0);
                end
                if (busy) busy_cyc++;
                pend_done = 1'b0;
                if (prev_stall) begin
                    chk(L, "hold_valid", 32'(pix_valid), 32'd1);
                    chk(L, "hold_data", 32'(pix_data), 32'(prev_data));
                end
                if (pix_valid) begin
                    chk(L, "busy_in_emit", 32'(busy), 32'd1);
                    chk(L, "data", 32'(pix_data), 32'(exp_idx % 256));
                    chk(L, "sof", 32'(pix_sof), 32'(exp_idx == 0));
                    chk(L, "eof", 32'(pix_eof), 32'(exp_idx == NPIX - 1));
                    chk(L, "addrb", 32'(addrb), 32'(exp_idx / 4));
`ifdef NIP_LINE_FLAGS_EN
                    chk(L, "eol", 32'(pix_eol), 32'(exp_idx % IMG_W == IMG_W - 1));
                    if (pix_eol && pix_ready) eol_cnt++;
`endif
                    if (pix_ready) begin
                        exp_idx++;
                        frame_pix++;
                        if (exp_idx == NPIX) begin
                            exp_idx   = 0;
                            pend_done = 1'b1;
                        end
                    end
                end
                prev_stall = pix_valid && !pix_ready;
                prev_data  = pix_data;
            end
        end

        task automatic cyc();
            @(posedge clk);
            #1;
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        endtask

        task automatic start_frame();
            frame_pix = 0;
            done_cnt  = 0;
            busy_cyc  = 0;
            eol_cnt   = 0;
            start     = 1'b1;
            cyc();
            start     = 1'b0;
        endtask

        task automatic wait_done(input string tag);
            int k = 0;
            while (!done && k < 12000) begin
                cyc();
                k++;
            end
            chk(L, tag, 32'(done), 32'd1);
        endtask

        initial begin
            rst       = 1'b1;
            start     = 1'b0;
            pix_ready = 1'b1;
            repeat (3) cyc();
            chk(L, "rst_busy", 32'(busy), 32'd0);
            chk(L, "rst_valid", 32'(pix_valid), 32'd0);
            chk(L, "rst_addrb", 32'(addrb), 32'd0);
            chk(L, "rst_done", 32'(done), 32'd0);
            chk(L, "rst_sof", 32'(pix_sof), 32'd0);
            chk(L, "rst_eof", 32'(pix_eof), 32'd0);
            chk(L, "rst_data", 32'(pix_data), 32'd0);
            rst = 1'b0;
            cyc();

            // Full frame, consumer always ready: exact throughput.
            rnd = 1'b0;
            start_frame();
            wait_done("s1_done_seen");
            repeat (3) cyc();
            chk(L, "s1_pixels", 32'(frame_pix), 32'(NPIX));
            chk(L, "s1_done_cnt", 32'(done_cnt), 32'd1);
            chk(L, "s1_busy_cycles", 32'(busy_cyc), 32'(NWORD * (5 + L)));
`ifdef NIP_LINE_FLAGS_EN
            chk(L, "s1_eol_cnt", 32'(eol_cnt), 32'(IMG_H));
`endif

            // Full frame with random backpressure.
            rnd = 1'b1;
            start_frame();
            wait_done("s2_done_seen");
            repeat (3) cyc();
            chk(L, "s2_pixels", 32'(frame_pix), 32'(NPIX));
            chk(L, "s2_done_cnt", 32'(done_cnt), 32'd1);

            // Start mid-frame is ignored; start in the done cycle chains a frame.
            start_frame();
            for (int k = 0; k < 5000 && frame_pix < 100; k++) cyc();
            chk(L, "s3_reached_100", 32'(frame_pix >= 100), 32'd1);
            start = 1'b1;
            cyc();
            start = 1'b0;
            wait_done("s3_done_seen");
            start = 1'b1;
            cyc();
            start = 1'b0;
            chk(L, "s3_first_pixels", 32'(frame_pix), 32'(NPIX));
            chk(L, "s3_first_done_cnt", 32'(done_cnt), 32'd1);
            chk(L, "s3_chained_busy", 32'(busy), 32'd1);
            frame_pix = 0;
            done_cnt  = 0;
            wait_done("s3_second_done_seen");
            repeat (3) cyc();
            chk(L, "s3_second_pixels", 32'(frame_pix), 32'(NPIX));
            chk(L, "s3_second_done_cnt", 32'(done_cnt), 32'd1);

            // Reset while emitting word 37 aborts the frame, then a clean restart.
            rnd = 1'b0;
            start_frame();
            for (int k = 0; k < 2000 && !(pix_valid && addrb == 9'd37); k++) cyc();
            chk(L, "s4_at_word37", 32'(pix_valid && addrb == 9'd37), 32'd1);
            rst = 1'b1;
            cyc();
            chk(L, "s4_valid", 32'(pix_valid), 32'd0);
            chk(L, "s4_busy", 32'(busy), 32'd0);
            chk(L, "s4_addrb", 32'(addrb), 32'd0);
            chk(L, "s4_done", 32'(done), 32'd0);
            rst = 1'b0;
            repeat (5) cyc();
            chk(L, "s4_no_done", 32'(done_cnt), 32'd0);
            start_frame();
            wait_done("s4_done_seen");
            repeat (3) cyc();
            chk(L, "s4_pixels", 32'(frame_pix), 32'(NPIX));
            chk(L, "s4_done_cnt", 32'(done_cnt), 32'd1);
            chk(L, "s4_busy_cycles", 32'(busy_cyc), 32'(NWORD * (5 + L)));

            fin = 1'b1;
        end
    end

    initial begin
        wait (inst_g[0].fin && inst_g[1].fin);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
